// File: rtl/div_seq_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
// Imported by div_seq and div_step.
package div_seq_pkg;

    localparam int REG_W = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor
// from the upper half, then shift in the quotient bit.
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = REG_W
) (
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH:0]   dividend_nxt
);

    logic [WIDTH:0] diff;

    assign diff = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

    assign dividend_nxt = diff[WIDTH]
        ? {dividend, 1'b0}
        : {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider for EX; returns
// {remainder, quotient} and stalls the pipe while running.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = REG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    div_state_e         state_q;
    div_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   dividend_q;
    logic [2*WIDTH:0]   dividend_nxt;
    logic [WIDTH-1:0]   divisor_q;
    logic               quo_neg_q;
    logic               rem_neg_q;
    logic               neg1;
    logic               neg2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic               go;

    assign go   = start_i & ~annul_i;
    assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
    assign mag1 = neg1 ? -opdata1_i : opdata1_i;
    assign mag2 = neg2 ? -opdata2_i : opdata2_i;

    assign quo_raw = dividend_q[WIDTH-1:0];
    assign rem_raw = dividend_q[2*WIDTH:WIDTH+1];
    assign quo_fin = quo_neg_q ? -quo_raw : quo_raw;
    assign rem_fin = rem_neg_q ? -rem_raw : rem_raw;

    assign busy_o = start_i & ~ready_o;

    div_step #(.WIDTH(WIDTH)) u_step (
        .dividend     (dividend_q[2*WIDTH-1:0]),
        .divisor      (divisor_q),
        .dividend_nxt (dividend_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_FREE: begin
                if (go) begin
                    state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: state_d = DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    cnt_q   <= '0;
                    ready_o <= 1'b0;
                    if (go) begin
                        dividend_q <= {{WIDTH{1'b0}}, mag1, 1'b0};
                        divisor_q  <= mag2;
                        quo_neg_q  <= neg1 ^ neg2;
                        rem_neg_q  <= neg1;
                    end
                end
                DIV_BY_ZERO: begin
                    result_o <= '0;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q != LAST_CNT) begin
                        dividend_q <= dividend_nxt;
                        cnt_q      <= cnt_q + 1'b1;
                    end else begin
                        result_o <= {rem_fin, quo_fin};
                        cnt_q    <= '0;
                    end
                end
                DIV_END: begin
                    // result stays held until EX drops its request
                    if (start_i == DIV_START) begin
                        ready_o <= 1'b1;
                    end else begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: ready_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed cases plus random operands checked
// against an arithmetic reference of quotient and remainder.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sg,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input int hold,
                           input logic chg);
        logic [63:0] exp;
        int lat;
        int bcnt;
        exp = ref_div(sg, a, b);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        chk("busy_on", 64'(busy_o), 64'd1);
        @(posedge clk); #1;
        lat  = 0;
        bcnt = 0;
        while (!ready_o && lat < 100) begin
            bcnt += int'(busy_o);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), (b == 0) ? 64'd2 : 64'd34);
        chk("busy_cyc", 64'(bcnt), (b == 0) ? 64'd2 : 64'd34);
        chk("result", result_o, exp);
        chk("busy_off", 64'(busy_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            if (chg) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            @(posedge clk); #1;
            chk("hold_rdy", 64'(ready_o), 64'd1);
            chk("hold_res", result_o, exp);
        end
        start_i = 1'b0;
        #1;
        chk("drop_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        chk("idle_rdy", 64'(ready_o), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [31:0] edge_v [4];
        int sel;
        edge_v[0] = 32'h8000_0000;
        edge_v[1] = 32'hFFFF_FFFF;
        edge_v[2] = 32'h0000_0001;
        edge_v[3] = 32'h7FFF_FFFF;

        rst = 1'b1;
        start_i = 1'b1;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", result_o, 64'd0);
        chk("rst_rdy", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd1);
        start_i = 1'b0;
        #1;
        chk("rst_busy0", 64'(busy_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_div(1'b0, 32'd5, 32'd0, 0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(1'b0, 32'd77, 32'd5, 5, 1'b0);
        run_div(1'b1, 32'hFFFF_FF00, 32'd9, 5, 1'b1);

        // annul mid-run, then reissue right away
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("annul_rdy", 64'(ready_o), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

        // annul while idle must hold off the start
        opdata1_i = 32'd50;
        opdata2_i = 32'd6;
        start_i = 1'b1;
        annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("blk_rdy", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        run_div(1'b0, 32'd50, 32'd6, 0, 1'b0);

        // reset in the middle of a run
        opdata1_i = 32'd12345;
        opdata2_i = 32'd17;
        start_i = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        chk("mrst_res", result_o, 64'd0);
        chk("mrst_rdy", 64'(ready_o), 64'd0);
        chk("mrst_busy", 64'(busy_o), 64'd1);
        rst = 1'b0;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        run_div(1'b1, 32'h8000_0000, 32'd7, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom;
            case (sel)
                1: b = 32'($urandom_range(1, 300));
                2: b = 32'd0;
                3: begin
                    a = edge_v[$urandom_range(0, 3)];
                    b = edge_v[$urandom_range(0, 3)];
                end
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_div(1'($urandom_range(0, 1)), a, b,
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle divide sequencer for the execution stage. It accepts a signed or unsigned 32-bit DIV/DIVU request from EX and runs a one-bit-per-cycle restoring division. It returns {remainder, quotient} for the HI/LO write path and holds the pipeline stalled while it works. It sits beside `ex`; EX drives the request and consumes `result_o` / `ready_o`.

## Interface
- `WIDTH`, default 32: operand width. The codebase uses only 32; `result_o` is 2×WIDTH.
- `clk`  in  1: pipeline clock.
- `rst`  in  1: reset, synchronous, active-high (`RstEnable`).
- `signed_div_i`  in  1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i`  in  WIDTH: dividend.
- `opdata2_i`  in  WIDTH: divisor.
- `start_i`  in  1: request level. EX holds it high until it sees `ready_o`.
- `annul_i`  in  1: cancels an in-flight divide (branch-delay/exception flush).
- `result_o`  out  2×WIDTH: {remainder[63:32] → HI, quotient[31:0] → LO}.
- `ready_o`  out  1: result valid.
- `busy_o`  out  1: stall request to `ctrl`. Equals `start_i & ~ready_o`, combinational.

## Operation
- FSM states:
  - IDLE: `start_i & ~annul_i` → BYZERO if divisor == 0, else RUN. Operands are captured at this edge.
  - BYZERO: → DONE next edge, result = 0.
  - RUN: `annul_i` → IDLE. Otherwise one iteration per edge. When cnt == WIDTH, → DONE and latch the result.
  - DONE: `ready_o` = 1 and `result_o` is held. `start_i` == 0 → IDLE. `start_i` still high → stay.
- Operand capture:
  - When signed and the operand MSB is 1, store its two's-complement magnitude.
  - Record the sign of quotient (s1 ^ s2) and the sign of remainder (s1).
- Datapath:
  - Working register `dividend[2×WIDTH:0]`, initialised to {WIDTH+1 zeros, |op1|} shifted left by 1.
  - Each iteration: `diff = {1'b0, dividend[2W-1:W]} - {1'b0, divisor}`.
  - If `diff` is negative: `dividend <= {dividend[2W-1:0], 1'b0}`.
  - Otherwise: `dividend <= {diff[W-1:0], dividend[W-1:0], 1'b1}`.
  - `cnt` is 6 bits and increments every iteration.
- Finalise:
  - quotient = `dividend[W-1:0]`; remainder = `dividend[2W:W+1]`.
  - Negate each as recorded, only when `signed_div_i` was set at capture.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0. No trap.
- `annul_i` in IDLE blocks a start. In DONE it has no effect; EX drops `start_i`.
- Operand changes after capture are ignored.
- Reset (any state, including mid-RUN) → IDLE, cnt = 0, `result_o` = 0, `ready_o` = 0.

## Timing
- Reset values: `result_o` = 0, `ready_o` = 0, `busy_o` = `start_i`.
- Start sampled at edge E0:
  - RUN at E0: iterations occur at E0+1 … E0+32.
  - DONE is entered at E0+33, and `ready_o` is high in the following cycle.
  - `busy_o` is high from when `start_i` rises until `ready_o` rises (34 stall cycles).
- Divide-by-zero: BYZERO at E0, DONE at E0+1, `ready_o` high 2 cycles after the start is sampled.
- DONE → IDLE on the edge where `start_i` == 0.
- A new `start_i` is accepted the cycle after returning to IDLE. Back-to-back divides therefore have a one-cycle gap.
- `annul_i` in RUN: IDLE on the next edge. `ready_o` never pulses for that request.
- Simultaneous `rst` and `annul_i`/`start_i`: `rst` wins.

## Structure
- Constants go in `defines.v`:
  - `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2-bit state codes).
  - `DivResultReady` / `DivResultNotReady`.
  - `DivStart` / `DivStop`.
  - Reuse `RstEnable`, `RegBus`, and `DoubleRegBus` (new, 63:0).
- The single module is `div_seq`. The iteration step (subtract/shift) may be split into the combinational sub-module `div_step`.
- The top level instantiates `div_seq` next to `ex`. EX muxes `result_o` into `hi_o`/`lo_o` with `whilo_o` = 1.

## Test plan
- Unsigned: 100 / 7 → `ready_o` 34 cycles after the start is sampled; `result_o` = {0x00000002, 0x0000000E}. `busy_o` is high for exactly 34 cycles.
- Signed: −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeated unsigned: quotient 0x7FFFFFFC, remainder 1.
- Divide-by-zero: 5 / 0 → `ready_o` after 2 cycles, `result_o` = 0, then IDLE once `start_i` drops.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Annul and reset:
  - `annul_i` at iteration 10 → IDLE, no `ready_o`. An immediately re-issued 9/3 then returns {0, 3} on time.
  - `rst` mid-RUN → all outputs 0 on the next cycle.
- Hold in DONE: keep `start_i` high for 5 cycles after ready → `result_o` stable and no restart. Then change the operands while in DONE → result unchanged.
